// File: rtl/axi_burst_write_master_pkg.sv
// Shared types and helpers for the AXI4 burst write master: response codes,
// FSM states, burst constants and response merging.
package axi_burst_write_master_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } wm_state_t;

    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam int         BOUNDARY_BYTES = 4096;

    // Worst response wins; EXOKAY carries no error so it folds into OKAY.
    function automatic axi_resp_t resp_merge(input axi_resp_t acc, input axi_resp_t resp);
        if (acc == RESP_DECERR || resp == RESP_DECERR) return RESP_DECERR;
        if (acc == RESP_SLVERR || resp == RESP_SLVERR) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_write_master_splitter.sv
// Combinational 4KB splitter: sizes the next INCR sub-burst so it never
// crosses a 4KB page, and gives the aligned address that follows it.
module axi_4kb_splitter
    import axi_burst_write_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [8:0]            remaining,
    input  logic [2:0]            size,
    output logic [8:0]            sub_beats,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] w_aligned;
    logic [12:0]           w_room;

    // NOTE: every output is assigned before any condition, so no latch is inferred.
    always_comb begin
        w_aligned = addr & ~((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1));
        w_room    = (13'(BOUNDARY_BYTES) - {1'b0, w_aligned[11:0]}) >> size;
        sub_beats = remaining;
        if ({4'b0000, remaining} > w_room) sub_beats = w_room[8:0];
        if (sub_beats > 9'd256) sub_beats = 9'd256;
        next_addr = w_aligned + (ADDR_WIDTH'(sub_beats) << size);
    end

endmodule

// File: rtl/axi_burst_write_master.sv
// AXI4 write-channel master: takes one command plus its data stream, issues
// 4KB-safe INCR sub-bursts one at a time and reports one merged completion.
module axi_burst_write_master
    import axi_burst_write_master_pkg::*;
#(
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic [3:0]            done_bursts,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    localparam int         LANE_BITS = $clog2(STRB_WIDTH);
    localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);

    wm_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [ADDR_WIDTH-1:0] r_beat_addr;
    logic [8:0]            r_remaining;
    logic [8:0]            r_sub;
    logic [8:0]            r_beat_cnt;
    logic [2:0]            r_size;
    axi_resp_t             r_resp_acc;
    axi_resp_t             r_done_resp;
    logic [3:0]            r_burst_cnt;
    logic [3:0]            r_done_bursts;
    logic                  r_first;
    logic                  r_cmd_ready;
    logic                  r_awvalid;
    logic                  r_wlast;
    logic                  r_bready;
    logic                  r_done_valid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_awlen;
    logic [2:0]            r_awsize;
    logic [STRB_WIDTH-1:0] r_wstrb;

    logic [8:0]            w_sub;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_in_w;
    logic                  w_beat;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_beat_next;
    axi_resp_t             w_merged;

    axi_4kb_splitter #(.ADDR_WIDTH(ADDR_WIDTH)) u_splitter (
        .addr      (r_addr),
        .remaining (r_remaining),
        .size      (r_size),
        .sub_beats (w_sub),
        .next_addr (w_next_addr)
    );

    // Lanes of the 2^size window holding this beat; the command's first beat
    // additionally drops the lanes below its unaligned start byte.
    function automatic logic [STRB_WIDTH-1:0] beat_strb(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [2:0] size,
                                                         input logic first);
        int off;
        int nb;
        int lo;
        off = int'(32'(addr) % 32'(STRB_WIDTH));
        nb  = int'(32'd1 << size);
        lo  = off & ~(nb - 1);
        for (int i = 0; i < STRB_WIDTH; i++) begin
            beat_strb[i] = (i >= lo) && (i < lo + nb) && (!first || i >= off);
        end
    endfunction

    assign w_in_w      = (r_state == ST_W);
    assign w_beat      = w_in_w && wr_valid && WREADY;
    assign w_step      = ADDR_WIDTH'(1) << r_size;
    assign w_beat_next = (r_beat_addr & ~(w_step - ADDR_WIDTH'(1))) + w_step;
    assign w_merged    = resp_merge(r_resp_acc, axi_resp_t'(BRESP));

    assign cmd_ready   = r_cmd_ready;
    assign wr_ready    = w_in_w && WREADY;
    assign WVALID      = w_in_w && wr_valid;
    assign WDATA       = wr_data;
    assign WSTRB       = r_wstrb;
    assign WLAST       = r_wlast;
    assign AWADDR      = r_awaddr;
    assign AWLEN       = r_awlen;
    assign AWSIZE      = r_awsize;
    assign AWBURST     = BURST_INCR;
    assign AWVALID     = r_awvalid;
    assign BREADY      = r_bready;
    assign done_valid  = r_done_valid;
    assign done_resp   = r_done_resp;
    assign done_bursts = r_done_bursts;

    // NOTE: state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values, avoiding simulation/synthesis mismatch.
    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_next_addr   <= '0;
            r_beat_addr   <= '0;
            r_remaining   <= '0;
            r_sub         <= '0;
            r_beat_cnt    <= '0;
            r_size        <= '0;
            r_resp_acc    <= RESP_OKAY;
            r_done_resp   <= RESP_OKAY;
            r_burst_cnt   <= '0;
            r_done_bursts <= '0;
            r_first       <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_awvalid     <= 1'b0;
            r_wlast       <= 1'b0;
            r_bready      <= 1'b0;
            r_done_valid  <= 1'b0;
            r_awaddr      <= '0;
            r_awlen       <= '0;
            r_awsize      <= '0;
            r_wstrb       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= {1'b0, cmd_len} + 9'd1;
                        r_size      <= cmd_size;
                        r_resp_acc  <= RESP_OKAY;
                        r_burst_cnt <= '0;
                        r_first     <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_size > MAX_SIZE) begin
                        r_resp_acc    <= RESP_SLVERR;
                        r_done_resp   <= RESP_SLVERR;
                        r_done_bursts <= r_burst_cnt;
                        r_done_valid  <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_sub       <= w_sub;
                        r_next_addr <= w_next_addr;
                        r_awaddr    <= r_addr;
                        r_awlen     <= 8'(w_sub - 9'd1);
                        r_awsize    <= r_size;
                        r_awvalid   <= 1'b1;
                        r_state     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (AWREADY) begin
                        r_awvalid   <= 1'b0;
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                        r_beat_cnt  <= '0;
                        r_beat_addr <= r_addr;
                        r_wstrb     <= beat_strb(r_addr, r_size, r_first);
                        r_wlast     <= (r_sub == 9'd1);
                        r_state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_beat) begin
                        r_first <= 1'b0;
                        if (r_wlast) begin
                            r_wlast  <= 1'b0;
                            r_wstrb  <= '0;
                            r_bready <= 1'b1;
                            r_state  <= ST_B;
                        end else begin
                            r_beat_cnt  <= r_beat_cnt + 9'd1;
                            r_beat_addr <= w_beat_next;
                            r_wstrb     <= beat_strb(w_beat_next, r_size, 1'b0);
                            r_wlast     <= (r_beat_cnt + 9'd2 == r_sub);
                        end
                    end
                end
                ST_B: begin
                    if (BVALID) begin
                        r_bready    <= 1'b0;
                        r_resp_acc  <= w_merged;
                        r_remaining <= r_remaining - r_sub;
                        r_addr      <= r_next_addr;
                        if (r_remaining == r_sub) begin
                            r_done_resp   <= w_merged;
                            r_done_bursts <= r_burst_cnt;
                            r_done_valid  <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_DONE: begin
                    r_done_valid <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Bench for axi_burst_write_master: byte-address model of each command,
// AXI slave responder, per-cycle compare process and directed scenarios.
module tb_axi_burst_write_master;

    logic        clk = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [3:0]  done_bursts;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;

    axi_burst_write_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .done_valid(done_valid), .done_resp(done_resp), .done_bursts(done_bursts),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } beat_t;
    typedef struct { logic [15:0] addr; logic [7:0] len; } aw_t;

    beat_t       exp_beat_q[$];
    aw_t         exp_aw_q[$];
    int          exp_resp_q[$];
    int          exp_bursts_q[$];
    logic [1:0]  bresp_q[$];
    logic [15:0] obs_aw_addr[$];
    logic [7:0]  obs_aw_len[$];
    int          obs_last[$];
    logic [3:0]  obs_strb[$];

    int          n_vec = 0;
    int          n_bad = 0;
    int          aws_seen, lasts_seen, obs_beats, obs_stall, done_cnt;
    int          acc_cyc, first_aw, done_cyc;
    int          aw_stall, data_idx;
    bit          wready_rand, aw_prev_stall;
    logic [15:0] held_addr;
    logic [7:0]  held_len;
    logic [2:0]  cur_size;
    logic [31:0] data_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte address of beat k: the start itself, then aligned start + k*2^size.
    function automatic logic [15:0] beat_addr(input logic [15:0] addr, input int size, input int k);
        int nb;
        nb = 1 << size;
        if (k == 0) return addr;
        return (addr & ~16'(nb - 1)) + 16'(k * nb);
    endfunction

    // Bursts close when the next beat sits on a different 4KB page.
    task automatic model_cmd(input logic [15:0] addr, input int len, input int size,
                             input logic [31:0] base);
        int nb, n, bursts, rank, run, lane;
        logic [15:0] a, an, start;
        beat_t b;
        aw_t   w;
        nb = 1 << size;
        n  = len + 1;
        if (size > 2) begin
            exp_resp_q.push_back(2);
            exp_bursts_q.push_back(0);
            return;
        end
        bursts = 0;
        run    = 0;
        start  = addr;
        for (int k = 0; k < n; k++) begin
            a = beat_addr(addr, size, k);
            if (run == 0) start = a;
            run++;
            lane   = int'(a[1:0]);
            b.data = base + 32'(k);
            b.strb = 4'b0000;
            for (int l = 0; l < 4; l++)
                if ((l / nb) == (lane / nb) && !(k == 0 && l < lane)) b.strb[l] = 1'b1;
            b.last = (k == n - 1);
            if (!b.last) begin
                an = beat_addr(addr, size, k + 1);
                if (an[15:12] != a[15:12]) b.last = 1'b1;
            end
            exp_beat_q.push_back(b);
            if (b.last) begin
                w.addr = start;
                w.len  = 8'(run - 1);
                exp_aw_q.push_back(w);
                bursts++;
                run = 0;
            end
        end
        rank = 0;
        for (int i = 0; i < bursts && i < bresp_q.size(); i++) begin
            if (bresp_q[i] == 2'b11) rank = 2;
            else if (bresp_q[i] == 2'b10 && rank < 1) rank = 1;
        end
        exp_resp_q.push_back(rank == 2 ? 3 : (rank == 1 ? 2 : 0));
        exp_bursts_q.push_back(bursts);
    endtask

    // Compare process and slave responder: samples on the falling edge, drives
    // slave inputs just after the rising edge.
    initial begin : slave_monitor
        bit    w_last_hs, b_hs, wr_hs;
        aw_t   ea;
        beat_t eb;
        forever begin
            @(negedge clk);
            w_last_hs = 0;
            b_hs      = 0;
            wr_hs     = 0;
            if (!ARESET) begin
                if (cmd_valid && cmd_ready) begin
                    acc_cyc  = cyc;
                    first_aw = -1;
                end
                if (AWVALID) begin
                    if (first_aw < 0) first_aw = cyc;
                    check("awburst", 32'(AWBURST), 32'h1);
                    if (aw_prev_stall) begin
                        check("aw_stable_addr", 32'(AWADDR), 32'(held_addr));
                        check("aw_stable_len", 32'(AWLEN), 32'(held_len));
                    end
                    held_addr = AWADDR;
                    held_len  = AWLEN;
                    if (AWREADY) begin
                        aw_prev_stall = 0;
                        aws_seen++;
                        obs_aw_addr.push_back(AWADDR);
                        obs_aw_len.push_back(AWLEN);
                        if (exp_aw_q.size() == 0) check("aw_unexpected", 32'h1, 32'h0);
                        else begin
                            ea = exp_aw_q.pop_front();
                            check("awaddr", 32'(AWADDR), 32'(ea.addr));
                            check("awlen", 32'(AWLEN), 32'(ea.len));
                            check("awsize", 32'(AWSIZE), 32'(cur_size));
                        end
                    end else begin
                        aw_prev_stall = 1;
                        obs_stall++;
                        if (aw_stall > 0) aw_stall--;
                    end
                end else begin
                    aw_prev_stall = 0;
                end
                if (WVALID && WREADY) begin
                    check("w_after_aw", 32'(lasts_seen < aws_seen), 32'h1);
                    obs_beats++;
                    obs_strb.push_back(WSTRB);
                    if (exp_beat_q.size() == 0) check("w_unexpected", 32'h1, 32'h0);
                    else begin
                        eb = exp_beat_q.pop_front();
                        check("wdata", WDATA, eb.data);
                        check("wstrb", 32'(WSTRB), 32'(eb.strb));
                        check("wlast", 32'(WLAST), 32'(eb.last));
                    end
                    if (WLAST) begin
                        lasts_seen++;
                        obs_last.push_back(obs_beats);
                        w_last_hs = 1;
                    end
                end
                wr_hs = wr_valid && wr_ready;
                b_hs  = BVALID && BREADY;
                if (done_valid) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (exp_resp_q.size() == 0) check("done_unexpected", 32'h1, 32'h0);
                    else begin
                        check("done_resp", 32'(done_resp), 32'(exp_resp_q.pop_front()));
                        check("done_bursts", 32'(done_bursts), 32'(exp_bursts_q.pop_front()));
                    end
                end
            end else begin
                aw_prev_stall = 0;
            end
            @(posedge clk);
            #1;
            if (ARESET) begin
                BVALID = 1'b0;
                BRESP  = 2'b00;
            end else begin
                if (w_last_hs) begin
                    BVALID = 1'b1;
                    BRESP  = 2'b00;
                    if (bresp_q.size() > 0) BRESP = bresp_q.pop_front();
                end else if (b_hs) begin
                    BVALID = 1'b0;
                end
                if (wr_hs) begin
                    data_idx++;
                    wr_data = data_base + 32'(data_idx);
                end
            end
            AWREADY = (aw_stall == 0);
            WREADY  = wready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic clear_obs();
        obs_aw_addr.delete();
        obs_aw_len.delete();
        obs_last.delete();
        obs_strb.delete();
        obs_beats = 0;
        obs_stall = 0;
    endtask

    task automatic run_cmd(input logic [15:0] addr, input int len, input int size,
                           input logic [31:0] base, input bit wait_done);
        int  d0;
        bit  ok;
        clear_obs();
        model_cmd(addr, len, size, base);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        cur_size  = 3'(size);
        data_base = base;
        data_idx  = 0;
        wr_data   = base;
        wr_valid  = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        cmd_size  = 3'(size);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
        end
        check("cmd_accept_timeout", 32'(ok), 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (wait_done) begin
            ok = 0;
            for (int i = 0; i < 2000 && !ok; i++) begin
                @(posedge clk);
                #2;
                ok = (done_cnt > d0);
            end
            check("done_timeout", 32'(ok), 32'h1);
            check("aw_left", 32'(exp_aw_q.size()), 32'h0);
            check("beats_left", 32'(exp_beat_q.size()), 32'h0);
        end
    endtask

    initial begin
        bit ok;
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        wr_valid = 1'b0; wr_data = '0;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00;
        aw_stall = 0; wready_rand = 0; aw_prev_stall = 0;
        aws_seen = 0; lasts_seen = 0; obs_beats = 0; obs_stall = 0; done_cnt = 0;
        acc_cyc = 0; first_aw = -1; done_cyc = 0; data_idx = 0; data_base = '0;
        cur_size = '0; held_addr = '0; held_len = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_valids", {26'b0, AWVALID, WVALID, WLAST, BREADY, wr_ready, done_valid}, 32'h0);
        check("rst_aw", {AWADDR, AWLEN, 5'b0, AWSIZE}, 32'h0);
        check("rst_misc", {22'b0, WSTRB, done_resp, done_bursts}, 32'h0);
        ARESET = 1'b0;

        // Single aligned burst.
        run_cmd(16'h0100, 3, 2, 32'hA000_0000, 1);
        check("t1_aw_count", 32'(obs_aw_addr.size()), 32'd1);
        check("t1_awaddr", 32'(obs_aw_addr[0]), 32'h0100);
        check("t1_awlen", 32'(obs_aw_len[0]), 32'd3);
        check("t1_wlast_beat", 32'(obs_last[0]), 32'd4);
        check("t1_strb", 32'(obs_strb[0]), 32'hF);
        check("t1_aw_latency", 32'(first_aw - acc_cyc), 32'd2);

        // 4KB boundary split.
        run_cmd(16'h0FE0, 15, 2, 32'hB000_0000, 1);
        check("t2_aw_count", 32'(obs_aw_addr.size()), 32'd2);
        check("t2_awaddr1", 32'(obs_aw_addr[0]), 32'h0FE0);
        check("t2_awaddr2", 32'(obs_aw_addr[1]), 32'h1000);
        check("t2_awlen1", 32'(obs_aw_len[0]), 32'd7);
        check("t2_awlen2", 32'(obs_aw_len[1]), 32'd7);
        check("t2_wlast1", 32'(obs_last[0]), 32'd8);
        check("t2_wlast2", 32'(obs_last[1]), 32'd16);

        // Unaligned single beat right under the boundary.
        run_cmd(16'h0FFB, 0, 2, 32'hC000_0000, 1);
        check("t3_awaddr", 32'(obs_aw_addr[0]), 32'h0FFB);
        check("t3_awlen", 32'(obs_aw_len[0]), 32'd0);
        check("t3_strb", 32'(obs_strb[0]), 32'h8);

        // Beat wider than the bus.
        run_cmd(16'h0200, 3, 3, 32'hD000_0000, 1);
        check("t4_no_aw", 32'(obs_aw_addr.size()), 32'd0);
        check("t4_done_latency", 32'(done_cyc - acc_cyc), 32'd2);

        // AW backpressure and SLVERR on the first sub-burst.
        bresp_q = '{2'b10, 2'b00};
        aw_stall = 5;
        run_cmd(16'h0FF0, 7, 2, 32'hE000_0000, 1);
        check("t5_stall_cycles", 32'(obs_stall), 32'd5);
        check("t5_awaddr2", 32'(obs_aw_addr[1]), 32'h1000);

        // Address wrap across 0xFFFF with EXOKAY then DECERR, WREADY jitter.
        wready_rand = 1;
        bresp_q = '{2'b01, 2'b11};
        run_cmd(16'hFFF8, 3, 2, 32'h1100_0000, 1);
        check("t6_awaddr2", 32'(obs_aw_addr[1]), 32'h0000);

        // Narrow unaligned beats.
        run_cmd(16'h0203, 2, 0, 32'h2200_0000, 1);
        check("t7_strb0", 32'(obs_strb[0]), 32'h8);
        check("t7_strb1", 32'(obs_strb[1]), 32'h1);
        run_cmd(16'h0301, 1, 1, 32'h3300_0000, 1);
        check("t8_strb0", 32'(obs_strb[0]), 32'h2);
        check("t8_strb1", 32'(obs_strb[1]), 32'hC);

        // Full 256-beat burst.
        run_cmd(16'h2000, 255, 2, 32'h4400_0000, 1);
        check("t9_awlen", 32'(obs_aw_len[0]), 32'd255);
        check("t9_beats", 32'(obs_beats), 32'd256);
        wready_rand = 0;

        // Reset during the second data beat.
        run_cmd(16'h0100, 3, 2, 32'h5500_0000, 0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (obs_beats == 1) && WVALID;
        end
        check("t10_reach_beat2", 32'(ok), 32'h1);
        ARESET = 1'b1;
        #1;
        check("t10_rst_valids", {26'b0, AWVALID, WVALID, WLAST, BREADY, wr_ready, done_valid}, 32'h0);
        check("t10_rst_ready", 32'(cmd_ready), 32'h1);
        check("t10_rst_regs", {AWADDR, AWLEN, WSTRB, done_resp, done_bursts[1:0]}, 32'h0);
        exp_aw_q.delete();
        exp_beat_q.delete();
        exp_resp_q.delete();
        exp_bursts_q.delete();
        bresp_q.delete();
        aws_seen = 0;
        lasts_seen = 0;
        ok = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            ok = ok | done_valid;
        end
        check("t10_no_done", 32'(ok), 32'h0);
        ARESET = 1'b0;
        run_cmd(16'h0100, 3, 2, 32'h6600_0000, 1);
        check("t10_after_bursts", 32'(obs_aw_addr.size()), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_burst_write_master.md
Name: axi_burst_write_master

Overview:
- Synthesizable AXI4 write-channel master that replaces hand-driven bench stimulus as the traffic source for the memory-mapped slave.
- Accepts one write command (address, total beats, size) and a matching data stream.
- Issues INCR bursts on AW/W/B, automatically splitting any command that crosses a 4KB boundary into legal sub-bursts.
- Returns one merged completion per command.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- DATA_WIDTH, 32, WDATA width in bits; power of two, 8..1024.
- STRB_WIDTH, DATA_WIDTH/8, WSTRB width (derived, not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master idle, command accepted on valid&&ready.
- cmd_addr  in  ADDR_WIDTH  start byte address; may be unaligned.
- cmd_len  in  8  beats minus one (1..256 beats).
- cmd_size  in  3  bytes per beat = 2^cmd_size.
- wr_valid  in  1  write data available.
- wr_ready  out  1  data beat consumed.
- wr_data  in  DATA_WIDTH  beat data.
- done_valid  out  1  one-cycle completion pulse.
- done_resp  out  2  merged response (OKAY/SLVERR/DECERR).
- done_bursts  out  4  sub-bursts issued for the command.
- AWADDR  out  ADDR_WIDTH  AXI write address.
- AWLEN  out  8  AXI burst length.
- AWSIZE  out  3  AXI burst size.
- AWBURST  out  2  constant 2'b01 (INCR).
- AWVALID  out  1  AXI address valid.
- AWREADY  in  1  AXI address ready.
- WDATA  out  DATA_WIDTH  AXI write data.
- WSTRB  out  STRB_WIDTH  AXI write strobes.
- WLAST  out  1  AXI last beat.
- WVALID  out  1  AXI data valid.
- WREADY  in  1  AXI data ready.
- BRESP  in  2  AXI write response.
- BVALID  in  1  AXI response valid.
- BREADY  out  1  AXI response ready.

Behaviour:
- Reset: state IDLE; cmd_ready=1; AWVALID, WVALID, WLAST, BREADY, wr_ready, done_valid = 0; AWADDR, AWLEN, AWSIZE, WSTRB, done_resp, done_bursts = 0.
- Reset mid-operation: the bus transaction is abandoned immediately; no completion pulse is generated.
- FSM states: IDLE, CHECK, AW, W, B, DONE.
- IDLE: cmd_ready=1. On accept, register addr, remaining = cmd_len+1, size; clear resp_acc and burst_cnt; go to CHECK.
- CHECK (1 cycle): if size > log2(STRB_WIDTH), set resp_acc=SLVERR and go to DONE with no bus activity. Otherwise compute the sub-burst and go to AW.
- Sub-burst computation:
  - aligned = addr with low size bits cleared.
  - room = (4096 - aligned[11:0]) >> size.
  - sub = min(remaining, room, 256).
  - AWLEN = sub-1; AWADDR = addr (unaligned start is preserved on the bus).
- AW: AWVALID=1; AWADDR/AWLEN/AWSIZE stable until AWREADY. On handshake, burst_cnt++ and go to W.
- W:
  - WVALID = wr_valid; wr_ready = WREADY; WDATA = wr_data; both sides are combinational pass-through.
  - Beat counter increments on WVALID&&WREADY.
  - WLAST = 1 on beat sub-1.
  - WSTRB: all bytes enabled within the 2^size lane window addressed by the beat. The first beat of the whole command clears lanes below the addr offset.
  - After the last beat, go to B.
- B: BREADY=1. On BVALID, merge into resp_acc with priority DECERR > SLVERR > OKAY; EXOKAY merges as OKAY.
  - remaining -= sub; addr = aligned + (sub << size).
  - If remaining > 0, go to CHECK; else go to DONE.
- DONE: done_valid=1 for exactly one cycle, with done_resp = resp_acc and done_bursts = burst_cnt; then IDLE.
- Latency: command accept to first AWVALID is 2 cycles.
- Ordering: only one sub-burst is outstanding at a time, and AW always precedes W.
- Address wraps modulo 2^ADDR_WIDTH; a wrap into the next 4KB page is treated as an ordinary boundary.
- A cmd_valid arriving while busy is held off (cmd_ready=0).

Decomposition:
- Shared package enuming: existing response enum (OKAY, EXOKAY, SLVERR, DECERR), plus new wm_state_t, BURST_INCR = 2'b01, BOUNDARY_BYTES = 4096, and the resp_merge function.
- One combinational sub-module, axi_4kb_splitter: inputs addr, remaining, size; outputs sub_beats and next_addr.

Test Plan:
- Single burst: addr 0x0100, len 3, size 2, no backpressure -> one AW (AWADDR=0x0100, AWLEN=3); 4 beats with WSTRB=4'hF and WLAST on beat 4; done_resp=OKAY, done_bursts=1.
- Boundary split: addr 0x0FE0, len 15, size 2 -> AW#1 0x0FE0/AWLEN=7, then AW#2 0x1000/AWLEN=7; 16 data beats total, WLAST on beats 8 and 16; done_bursts=2.
- Unaligned edge: addr 0x0FFB, len 0, size 2 -> AWADDR=0x0FFB, AWLEN=0, WSTRB=4'b1000, no split; done_bursts=1.
- Illegal size: size 3 with DATA_WIDTH=32 -> AWVALID never asserted; done_resp=SLVERR, done_bursts=0, 2 cycles after accept.
- Response merge plus backpressure: split command with AWREADY held low 5 cycles and the first BRESP=SLVERR, second OKAY -> AWADDR stable while stalled; done_resp=SLVERR.
- Reset mid-burst: ARESET asserted during W beat 2 -> all outputs at reset values immediately and no done_valid; after release a new 0x0100/len 3 command completes with OKAY.
